// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw board pins in, debounced level and edge pulses out.
// The conditioner takes the slave view. Whoever drives the pins takes the master view.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronizes each key, debounces it with a per-channel FSM,
// and emits registered press/release pulses.
module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    key_conditioner_if.slave  keys
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [NUM_KEYS-1:0] RELEASED_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_raw;
    logic [NUM_KEYS-1:0] key_sync;

    // Synchronizers idle at the released pin level, so a key held through reset still reads as a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= RELEASED_LEVEL;
            sync_raw  <= RELEASED_LEVEL;
        end else begin
            sync_meta <= keys.key_raw;
            sync_raw  <= sync_meta;
        end
    end

    assign key_sync = (ACTIVE_LOW != 0) ? ~sync_raw : sync_raw;

    typedef enum logic {STABLE, PENDING} state_t;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        state_t           state, state_next;
        logic [CNT_W-1:0] count, count_next;
        logic             accept;
        logic             level_r, press_r, release_r;
        logic             differs;

        assign differs = key_sync[i] != level_r;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= STABLE;
                count     <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                state     <= state_next;
                count     <= count_next;
                level_r   <= accept ? key_sync[i] : level_r;
                press_r   <= accept & key_sync[i];
                release_r <= accept & ~key_sync[i];
            end
        end

        // A one-cycle debounce accepts straight from STABLE and never waits in PENDING.
        always_comb begin
            state_next = state;
            case (state)
                STABLE:  if (differs && DEBOUNCE_CYCLES != 1) state_next = PENDING;
                PENDING: if (!differs || count == CNT_MAX)    state_next = STABLE;
                default: state_next = STABLE;
            endcase
        end

        always_comb begin
            count_next = '0;
            accept     = 1'b0;
            case (state)
                STABLE: begin
                    if (differs) begin
                        if (DEBOUNCE_CYCLES == 1) accept = 1'b1;
                        else                      count_next = CNT_W'(1);
                    end
                end
                PENDING: begin
                    if (differs) begin
                        if (count == CNT_MAX) accept = 1'b1;
                        else                  count_next = count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        assign keys.key_level[i]   = level_r;
        assign keys.key_press[i]   = press_r;
        assign keys.key_release[i] = release_r;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with two active-low keys and a 4-cycle debounce.
// Inputs change at the falling edge, and outputs are sampled at the falling edge.
module tb_key_conditioner;

    logic clk = 1'b0;
    logic reset_n;
    int total = 0;
    int bad = 0;
    int press_cnt0 = 0, press_cnt1 = 0, release_cnt0 = 0, release_cnt1 = 0;
    int overlap_seen = 0;
    int snap_p0, snap_p1, snap_r0, snap_r1;
    logic [1:0] level_or;

    key_conditioner_if #(.NUM_KEYS(2)) keys ();

    key_conditioner #(
        .NUM_KEYS(2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .keys(keys)
    );

    always #5 clk = ~clk;

    // Counts output pulses just after each rising edge, for whole-window checks.
    always begin
        @(posedge clk);
        #1;
        if (keys.key_press[0])   press_cnt0++;
        if (keys.key_press[1])   press_cnt1++;
        if (keys.key_release[0]) release_cnt0++;
        if (keys.key_release[1]) release_cnt1++;
        if ((keys.key_press & keys.key_release) != 2'b00) overlap_seen++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] raw);
        keys.key_raw = raw;
    endtask

    task automatic snapshot();
        snap_p0 = press_cnt0;
        snap_p1 = press_cnt1;
        snap_r0 = release_cnt0;
        snap_r1 = release_cnt1;
    endtask

    initial begin
        int rem0, rem1, n0, n1;
        logic [1:0] raw;

        // V-1: reset with both keys released
        reset_n = 1'b0;
        applyStimulus(2'b11);
        step(3);
        checkOutput("v1_level_in_reset", int'(keys.key_level), 0);
        checkOutput("v1_press_in_reset", int'(keys.key_press), 0);
        checkOutput("v1_release_in_reset", int'(keys.key_release), 0);
        reset_n = 1'b1;
        step(10);
        checkOutput("v1_level_after", int'(keys.key_level), 0);
        checkOutput("v1_pulses_after", press_cnt0 + press_cnt1 + release_cnt0 + release_cnt1, 0);

        // V-2: clean press of key 0, accepted on the sixth edge
        applyStimulus(2'b10);
        step(6);
        checkOutput("v2_level_edge5", int'(keys.key_level), 0);
        step(1);
        checkOutput("v2_level_edge6", int'(keys.key_level), 1);
        checkOutput("v2_press_edge6", int'(keys.key_press), 1);
        step(1);
        checkOutput("v2_press_edge7", int'(keys.key_press), 0);
        checkOutput("v2_level_edge7", int'(keys.key_level), 1);
        applyStimulus(2'b11);
        step(6);
        checkOutput("v2_rel_level_edge5", int'(keys.key_level), 1);
        step(1);
        checkOutput("v2_rel_level_edge6", int'(keys.key_level), 0);
        checkOutput("v2_release_edge6", int'(keys.key_release), 1);
        step(1);
        checkOutput("v2_release_edge7", int'(keys.key_release), 0);

        // V-3: three low, one high bounce, then steady low
        snapshot();
        applyStimulus(2'b10);
        step(3);
        applyStimulus(2'b11);
        step(1);
        applyStimulus(2'b10);
        step(6);
        checkOutput("v3_level_before", int'(keys.key_level), 0);
        step(1);
        checkOutput("v3_level_accept", int'(keys.key_level), 1);
        checkOutput("v3_press_accept", int'(keys.key_press), 1);
        step(5);
        checkOutput("v3_press_count", press_cnt0 - snap_p0, 1);
        applyStimulus(2'b11);
        step(10);
        checkOutput("v3_level_released", int'(keys.key_level), 0);
        checkOutput("v3_release_count", release_cnt0 - snap_r0, 1);

        // V-4: both keys together, released 20 clocks later
        applyStimulus(2'b00);
        step(6);
        checkOutput("v4_level_before", int'(keys.key_level), 0);
        step(1);
        checkOutput("v4_press_both", int'(keys.key_press), 3);
        checkOutput("v4_level_both", int'(keys.key_level), 3);
        step(1);
        checkOutput("v4_press_cleared", int'(keys.key_press), 0);
        step(12);
        applyStimulus(2'b11);
        step(6);
        checkOutput("v4_level_held", int'(keys.key_level), 3);
        step(1);
        checkOutput("v4_release_both", int'(keys.key_release), 3);
        checkOutput("v4_level_released", int'(keys.key_level), 0);
        step(1);
        checkOutput("v4_release_cleared", int'(keys.key_release), 0);

        // V-5: reset in the middle of a pending press of key 1
        snapshot();
        applyStimulus(2'b01);
        step(4);
        reset_n = 1'b0;
        step(2);
        checkOutput("v5_level_in_reset", int'(keys.key_level), 0);
        checkOutput("v5_no_press_by_reset", press_cnt1 - snap_p1, 0);
        reset_n = 1'b1;
        step(6);
        checkOutput("v5_level_edge5", int'(keys.key_level), 0);
        step(1);
        checkOutput("v5_level_edge6", int'(keys.key_level), 2);
        checkOutput("v5_press_edge6", int'(keys.key_press), 2);
        step(1);
        checkOutput("v5_press_count", press_cnt1 - snap_p1, 1);
        applyStimulus(2'b11);
        step(10);
        checkOutput("v5_level_released", int'(keys.key_level), 0);

        // V-6: glitch trains on both keys, every low run of three clocks or fewer
        snapshot();
        level_or = 2'b00;
        raw = 2'b11;
        rem0 = 1;
        rem1 = 2;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 1000; c++) begin
            if (rem0 == 0) begin
                raw[0] = ~raw[0];
                rem0 = raw[0] ? (n0 % 2) + 1 : (n0 % 3) + 1;
                n0++;
            end
            if (rem1 == 0) begin
                raw[1] = ~raw[1];
                rem1 = raw[1] ? (n1 % 4) + 1 : ((n1 + 1) % 3) + 1;
                n1++;
            end
            rem0--;
            rem1--;
            applyStimulus(raw);
            step(1);
            level_or = level_or | keys.key_level;
        end
        applyStimulus(2'b11);
        step(10);
        checkOutput("v6_level_never_set", int'(level_or), 0);
        checkOutput("v6_level_final", int'(keys.key_level), 0);
        checkOutput("v6_no_press", (press_cnt0 - snap_p0) + (press_cnt1 - snap_p1), 0);
        checkOutput("v6_no_release", (release_cnt0 - snap_r0) + (release_cnt1 - snap_r1), 0);

        checkOutput("press_release_overlap", overlap_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
